antirebote_multicanal: RTL
==========================

ANTIREBOTE_MULTICANAL -- requirements
Module: antirebote_multicanal

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 10000: consecutive stable cycles required to accept a new level (>=1).
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flip-flop depth per channel (>=2).
REQ-004 Parameter LONG_CYCLES, default 250000000: cycles a debounced high level must persist to flag a long press (> DEBOUNCE_CYCLES).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pin_in  input  N_CH  raw asynchronous button/sensor levels, one bit per channel.
REQ-008 toggle_clr  input  N_CH  synchronous per-channel clear of toggle_out.
REQ-009 level_out  output  N_CH  debounced level per channel.
REQ-010 rise_pulse  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-011 fall_pulse  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-012 toggle_out  output  N_CH  flips on each debounced 1->0 (press-release toggle).
REQ-013 long_pulse  output  N_CH  one-cycle pulse when debounced high reaches LONG_CYCLES.

Function
REQ-014 Each channel SHALL pass pin_in through SYNC_STAGES flip-flops before any other logic; channels SHALL be fully independent.
REQ-015 Each channel SHALL hold a debounce counter of width $clog2(DEBOUNCE_CYCLES+1), cleared in any cycle where synchronised input equals level_out.
REQ-016 While synchronised input differs from level_out the counter SHALL increment; on the cycle it would reach DEBOUNCE_CYCLES, level_out SHALL take the synchronised value and the counter SHALL clear.
REQ-017 Latency: a clean pin_in edge SHALL appear on level_out exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges later.
REQ-018 Any return of synchronised input to level_out before the count completes SHALL restart the count from zero (glitch rejected, no output activity).
REQ-019 rise_pulse/fall_pulse SHALL be registered and high for exactly one cycle, in the same cycle level_out first shows the new value.
REQ-020 toggle_out SHALL invert on the same clock edge level_out goes 1->0; no change on 0->1.
REQ-021 toggle_clr high SHALL force toggle_out to 0 on the next edge; if toggle_clr coincides with a 1->0 transition, clear SHALL win.
REQ-022 Each channel SHALL hold a hold counter of width $clog2(LONG_CYCLES+1), counting cycles with level_out=1 and cleared while level_out=0.
REQ-023 long_pulse SHALL assert for one cycle when the hold counter reaches LONG_CYCLES; the counter SHALL then saturate, giving at most one long_pulse per press.
REQ-024 A release after long_pulse SHALL still produce fall_pulse and toggle_out inversion.
REQ-025 No output SHALL be combinationally dependent on pin_in or toggle_clr.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) clear synchronisers, all counters, level_out, rise_pulse, fall_pulse, toggle_out and long_pulse to 0.
REQ-027 After reset deassertion, a pin_in held at 1 SHALL be treated as a new 0->1 edge and produce rise_pulse after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
REQ-028 Reset asserted mid-count or mid-press SHALL discard the count with no pulse emitted.

Verification (N_CH=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_CYCLES=32)
REQ-029 pin_in[0] 0->1 held -> level_out[0]=1 and rise_pulse[0]=1 for one cycle exactly 10 edges after the change; other channels unchanged.
REQ-030 pin_in[1] bursts of 1 lasting 3,5,7 cycles separated by 2-cycle lows -> level_out[1], pulses and toggle_out[1] stay 0.
REQ-031 Two clean press/release cycles on ch2 (20 cycles each) -> two fall_pulse[2], toggle_out[2] goes 1 then 0.
REQ-032 ch3 held high 60 cycles -> exactly one long_pulse[3], 32 cycles after rise_pulse[3]; release -> fall_pulse[3], toggle_out[3]=1.
REQ-033 toggle_clr[2] asserted in same cycle as fall_pulse[2] would toggle 0->1 -> toggle_out[2]=0.
REQ-034 reset pulsed while ch0 count=5 and ch3 hold=20 -> all outputs 0 immediately; no rise_pulse or long_pulse until fresh full counts after release.

Source files
------------

// File: rtl/antirebote_multicanal.sv
// Multi-channel button debouncer with synchroniser, edge pulses,
// press-release toggle and long-press detection per channel.
module antirebote_multicanal #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SYNC_STAGES     = 2,
  parameter int LONG_CYCLES     = 250000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pin_in,
  input  logic [N_CH-1:0] toggle_clr,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out,
  output logic [N_CH-1:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] r_sync;
  logic [N_CH-1:0][DW-1:0]          r_dcnt;
  logic [N_CH-1:0][HW-1:0]          r_hcnt;
  logic [N_CH-1:0]                  w_sync;
  logic [N_CH-1:0]                  w_diff;
  logic [N_CH-1:0]                  w_done;

  always_comb begin
    w_sync = '0;
    w_diff = '0;
    w_done = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_sync[c] = r_sync[c][SYNC_STAGES-1];
      w_diff[c] = w_sync[c] ^ level_out[c];
      w_done[c] = w_diff[c] && (r_dcnt[c] == D_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_dcnt     <= '0;
      r_hcnt     <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      toggle_out <= '0;
      long_pulse <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], pin_in[c]};
        rise_pulse[c] <= 1'b0;
        fall_pulse[c] <= 1'b0;
        long_pulse[c] <= 1'b0;

        if (!w_diff[c]) begin
          r_dcnt[c] <= '0;
        end else if (w_done[c]) begin
          r_dcnt[c]     <= '0;
          level_out[c]  <= w_sync[c];
          rise_pulse[c] <= w_sync[c];
          fall_pulse[c] <= ~w_sync[c];
        end else begin
          r_dcnt[c] <= r_dcnt[c] + DW'(1);
        end

        // clear beats a coincident release
        if (toggle_clr[c]) begin
          toggle_out[c] <= 1'b0;
        end else if (w_done[c] && !w_sync[c]) begin
          toggle_out[c] <= ~toggle_out[c];
        end

        if (!level_out[c]) begin
          r_hcnt[c] <= '0;
        end else if (r_hcnt[c] != H_MAX) begin
          r_hcnt[c]     <= r_hcnt[c] + HW'(1);
          long_pulse[c] <= (r_hcnt[c] == H_PRE);
        end
      end
    end
  end

endmodule
